// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions: ALUControl codes and the mul sequencer state encoding.
package mips_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_MUL  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_BGEZ = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BGTZ = 4'd12;
  localparam logic [3:0] ALU_BLEZ = 4'd13;
  localparam logic [3:0] ALU_BLTZ = 4'd14;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath for the mul sequencer: multiplicand, multiplier and accumulator
// registers, advanced one multiplier bit per step strobe.
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc,
  output logic             rest_zero
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] addend;

  assign addend = mplier[0] ? mcand : '0;

  // True when no set multiplier bits remain once this step's shift is applied.
  assign rest_zero = (mplier[WIDTH-1:1] == '0);

  // NOTE: every register here uses <= so all three update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc + addend;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle mul engine beside the EX-stage ALU; stalls the pipeline until the product is ready.
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_sequencer
  import mips_alu_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = ALU_MUL
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic [WIDTH-1:0] Result,
  output logic             Done,
  output logic             Busy,
  output logic             Stall
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CW-1:0]    count;
  logic             accept;
  logic             step;
  logic             last;
  logic             rest_zero;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result_q;

  assign accept = Start && (ALUControl == MUL_CODE) && (state == S_IDLE) && !Flush;
  assign step   = (state == S_RUN) && !Flush;

`ifdef MUL_EARLY_EXIT_EN
  assign last = (count == CW'(WIDTH - 1)) || rest_zero;
`else
  assign last = (count == CW'(WIDTH - 1));
`endif

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (Clk),
    .reset    (Reset),
    .load     (accept),
    .step     (step),
    .a        (A),
    .b        (B),
    .acc      (acc),
    .rest_zero(rest_zero)
  );

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_RUN;
      S_RUN: begin
        if (Flush)     state_next = S_IDLE;
        else if (last) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      count    <= '0;
      Busy     <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_next;
      Busy  <= (state_next != S_IDLE);
      if (accept)    count    <= '0;
      else if (step) count    <= count + CW'(1);
      if (Done)      result_q <= acc;
    end
  end

  // A flush in the DONE cycle suppresses the pulse and leaves the held result untouched.
  assign Done   = (state == S_DONE) && !Flush;
  assign Result = Done ? acc : result_q;
  assign Stall  = accept || (state == S_RUN);

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: scoreboard of expected products, latency and stall checks.
// Honours MUL_EARLY_EXIT_EN for the expected latency.
module tb_mul_sequencer;
  import mips_alu_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  ALUControl = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Flush = 1'b0;
  logic [31:0] Result;
  logic        Done;
  logic        Busy;
  logic        Stall;

  int          vectors = 0;
  int          misses = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;
  logic [31:0] cur_b = '0;

  mul_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .ALUControl(ALUControl),
    .A         (A),
    .B         (B),
    .Flush     (Flush),
    .Result    (Result),
    .Done      (Done),
    .Busy      (Busy),
    .Stall     (Stall)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n + 1;
`else
    return 33;
`endif
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
    logic [31:0] p;
    @(negedge Clk);
    Start = 1'b1; ALUControl = ALU_MUL; A = a; B = b; cur_b = b;
    #1;
    check("accept_stall", {31'b0, Stall}, 32'd1);
    p = a * b;
    if (push) exp_q.push_back(p);
  endtask

  task automatic wait_done(input bit hold);
    int cyc, stall_hi, lat;
    bit seen;
    logic [31:0] exp;
    lat = exp_latency(cur_b);
    cyc = 0; stall_hi = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (!hold) Start = 1'b0;
      #1;
      if (Done === 1'b1) seen = 1;
      else if (Stall === 1'b1) stall_hi++;
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    check("latency", cyc, lat);
    check("stall_run", stall_hi, lat - 1);
    check("stall_done", {31'b0, Stall}, 32'd0);
    check("busy_done", {31'b0, Busy}, 32'd1);
    if (exp_q.size() == 0) begin
      vectors++; misses++;
      $display("FAIL scoreboard: observed result %h expected none queued", Result);
    end else begin
      exp = exp_q.pop_front();
      check("result", Result, exp);
      last_result = exp;
    end
    if (!hold) begin
      @(negedge Clk); #1;
      check("done_pulse", {31'b0, Done}, 32'd0);
      check("busy_idle", {31'b0, Busy}, 32'd0);
      check("result_hold", Result, last_result);
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    issue(a, b, 1'b1);
    wait_done(1'b0);
  endtask

  initial begin
    int d;
    // Reset state
    repeat (2) @(negedge Clk);
    #1;
    check("rst_result", Result, 32'd0);
    check("rst_done", {31'b0, Done}, 32'd0);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_stall", {31'b0, Stall}, 32'd0);
    Reset = 1'b0;

    // Basic products and wrap-around
    run_mul(32'd7, 32'd6);
    run_mul(32'hFFFF_FFFF, 32'd5);
    run_mul(32'h8000_0000, 32'd2);

    // Non-mul code is ignored
    @(negedge Clk);
    Start = 1'b1; ALUControl = ALU_ADD; A = 32'd3; B = 32'd4;
    #1;
    check("add_stall", {31'b0, Stall}, 32'd0);
    d = 0;
    repeat (4) begin
      @(negedge Clk); #1;
      if (Busy !== 1'b0 || Done !== 1'b0 || Stall !== 1'b0) d++;
    end
    Start = 1'b0;
    check("add_ignored", d, 0);

    // Flush mid-operation: no Done, Result keeps the previous product
    run_mul(32'h0000_1234, 32'h0001_0001);
    issue(32'd5, 32'hF000_0001, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (c == 10) Flush = 1'b1;
    end
    @(negedge Clk);
    Flush = 1'b0;
    #1;
    check("flush_busy", {31'b0, Busy}, 32'd0);
    check("flush_done", {31'b0, Done}, 32'd0);
    check("flush_stall", {31'b0, Stall}, 32'd0);
    check("flush_result", Result, last_result);
    d = 0;
    repeat (40) begin
      @(negedge Clk); #1;
      if (Done === 1'b1) d++;
    end
    check("flush_no_done", d, 0);
    run_mul(32'd11, 32'd13);

    // Reset mid-operation
    issue(32'd3, 32'hFFFF_FFFF, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (c == 20) Reset = 1'b1;
    end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("mid_rst_result", Result, 32'd0);
    check("mid_rst_done", {31'b0, Done}, 32'd0);
    check("mid_rst_busy", {31'b0, Busy}, 32'd0);
    check("mid_rst_stall", {31'b0, Stall}, 32'd0);
    last_result = '0;

    // Held Start: no re-accept in DONE, re-accept on the following IDLE cycle
    issue(32'h0000_FFFF, 32'h0000_FFFF, 1'b1);
    wait_done(1'b1);
    @(negedge Clk); #1;
    check("reaccept_stall", {31'b0, Stall}, 32'd1);
    check("reaccept_busy", {31'b0, Busy}, 32'd0);
    check("reaccept_done", {31'b0, Done}, 32'd0);
    exp_q.push_back(32'hFFFE_0001);
    wait_done(1'b0);

    // Multiplier boundaries (short latency when early exit is built in)
    run_mul(32'd9, 32'd0);
    run_mul(32'd9, 32'd3);
    run_mul(32'd9, 32'd1);
    run_mul(32'd1, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
